// File: rtl/m_mem_stage_pkg.sv
// Shared definitions for the M stage: opcodes, control-unit select codes and
// the decode function used to interpret the resident instruction.
package m_mem_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef enum logic [1:0] {A3_RT, A3_RD, A3_RA} grfa3_sel_e;
  typedef enum logic [1:0] {WD_ALU, WD_DM, WD_PC8} grfwd_sel_e;
  typedef enum logic [1:0] {ST_NONE, ST_SW, ST_SH, ST_SB} store_e;
  typedef enum logic [2:0] {LD_NONE, LD_LW, LD_LH, LD_LHU, LD_LB, LD_LBU} load_e;

  typedef struct packed {
    grfa3_sel_e a3_sel;
    grfwd_sel_e wd_sel;
    logic       rf_wr;
    store_e     st;
    load_e      ld;
  } ctrl_t;

  // An all-zero instruction is a nop and must not claim a register write.
  function automatic ctrl_t cu_decode(input logic [5:0] op, input logic [5:0] fn,
                                      input logic is_nop);
    ctrl_t c;
    c.a3_sel = A3_RT;
    c.wd_sel = WD_ALU;
    c.rf_wr  = 1'b0;
    c.st     = ST_NONE;
    c.ld     = LD_NONE;
    if (!is_nop) begin
      case (op)
        OP_RTYPE: begin
          if (fn != FN_JR) begin
            c.rf_wr  = 1'b1;
            c.a3_sel = A3_RD;
            if (fn == FN_JALR) c.wd_sel = WD_PC8;
          end
        end
        OP_JAL: begin
          c.rf_wr  = 1'b1;
          c.a3_sel = A3_RA;
          c.wd_sel = WD_PC8;
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c.rf_wr = 1'b1;
        OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
          c.rf_wr  = 1'b1;
          c.wd_sel = WD_DM;
          case (op)
            OP_LW:   c.ld = LD_LW;
            OP_LH:   c.ld = LD_LH;
            OP_LHU:  c.ld = LD_LHU;
            OP_LB:   c.ld = LD_LB;
            default: c.ld = LD_LBU;
          endcase
        end
        OP_SW:   c.st = ST_SW;
        OP_SH:   c.st = ST_SH;
        OP_SB:   c.st = ST_SB;
        default: ;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/m_mem_stage_dm.sv
// m_dm: word-organised data memory with per-byte write enables, a
// synchronous whole-array clear and an asynchronous (read-old) read port.
module m_dm #(
  parameter int DM_WORDS = 4096,
  parameter int DM_AW    = 12
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       be,
  input  logic [DM_AW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DM_WORDS];

  // Clear takes priority, so a store coinciding with reset is dropped.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/m_mem_stage_reg.sv
// M_REG: the IR/PC/AO/V2 pipeline register between E and M. A clear wins
// over the write enable; with the enable low the contents are held.
module M_REG (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        We,
  input  logic [31:0] IR_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] AO_in,
  input  logic [31:0] V2_in,
  output logic [31:0] IR_out,
  output logic [31:0] PC_out,
  output logic [31:0] AO_out,
  output logic [31:0] V2_out
);

  logic [31:0] ir_q, pc_q, ao_q, v2_q;
  logic [31:0] ir_d, pc_d, ao_d, v2_d;

  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    ao_d = ao_q;
    v2_d = v2_q;
    if (We) begin
      ir_d = IR_in;
      pc_d = PC_in;
      ao_d = AO_in;
      v2_d = V2_in;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      ir_q <= '0;
      pc_q <= '0;
      ao_q <= '0;
      v2_q <= '0;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
      ao_q <= ao_d;
      v2_q <= v2_d;
    end
  end

  assign IR_out = ir_q;
  assign PC_out = pc_q;
  assign AO_out = ao_q;
  assign V2_out = v2_q;

endmodule

// File: rtl/m_mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline: pipeline register, data memory
// access with byte/half/word granularity, and forwarding info for D and E.
module m_mem_stage
  import m_mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 4096,
  parameter int DM_AW    = 12
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Reg_Rst,
  input  logic        We,
  input  logic [31:0] IR_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Y_in,
  input  logic [31:0] V2_in,
  input  logic [4:0]  W_RFA3_in,
  input  logic [31:0] W_RFWD_in,
  input  logic        W_RFWr_in,
  input  logic        W_Forward_Ready_in,
  output logic [31:0] IR_out,
  output logic [31:0] PC_out,
  output logic [31:0] AO_out,
  output logic [31:0] DR_out,
  output logic [4:0]  M_RFA3_out,
  output logic [31:0] M_RFWD_out,
  output logic        M_RFWr_out,
  output logic        M_Forward_Ready_out
);

  logic [31:0]      v2;
  ctrl_t            ctrl;
  logic [4:0]       rt, rd;
  logic             w_fwd;
  logic [31:0]      st_data;
  logic [3:0]       dm_be;
  logic [31:0]      dm_wdata;
  logic [31:0]      rd_word;
  logic [DM_AW-1:0] dm_addr;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  M_REG u_m_reg (
    .Clk    (Clk),
    .Clr    (Rst | Reg_Rst),
    .We     (We),
    .IR_in  (IR_in),
    .PC_in  (PC_in),
    .AO_in  (Y_in),
    .V2_in  (V2_in),
    .IR_out (IR_out),
    .PC_out (PC_out),
    .AO_out (AO_out),
    .V2_out (v2)
  );

  assign ctrl = cu_decode(IR_out[31:26], IR_out[5:0], IR_out == 32'h0);
  assign rt   = IR_out[20:16];
  assign rd   = IR_out[15:11];

  // W-stage data overrides the stale rt value latched from E.
  assign w_fwd   = (rt != 5'd0) && (rt == W_RFA3_in) && W_RFWr_in && W_Forward_Ready_in;
  assign st_data = w_fwd ? W_RFWD_in : v2;
  assign dm_addr = AO_out[DM_AW+1:2];

  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = st_data;
    case (ctrl.st)
      ST_SW: dm_be = 4'b1111;
      ST_SH: begin
        dm_be    = AO_out[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{st_data[15:0]}};
      end
      ST_SB: begin
        dm_be    = 4'b0001 << AO_out[1:0];
        dm_wdata = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  m_dm #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_m_dm (
    .Clk   (Clk),
    .Rst   (Rst),
    .be    (dm_be),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (rd_word)
  );

  always_comb begin
    case (AO_out[1:0])
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = AO_out[1] ? rd_word[31:16] : rd_word[15:0];
    case (ctrl.ld)
      LD_LB:   DR_out = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  DR_out = {24'h0, sel_byte};
      LD_LH:   DR_out = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  DR_out = {16'h0, sel_half};
      default: DR_out = rd_word;
    endcase
  end

  // Load results only become final in W, so loads hold off forwarding.
  always_comb begin
    M_RFA3_out = 5'd0;
    if (ctrl.rf_wr) begin
      case (ctrl.a3_sel)
        A3_RT:   M_RFA3_out = rt;
        A3_RD:   M_RFA3_out = rd;
        A3_RA:   M_RFA3_out = 5'd31;
        default: M_RFA3_out = 5'd0;
      endcase
    end
    M_RFWr_out          = ctrl.rf_wr;
    M_RFWD_out          = (ctrl.wd_sel == WD_PC8) ? PC_out + 32'd8 : AO_out;
    M_Forward_Ready_out = (ctrl.ld == LD_NONE);
  end

endmodule
